id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between the decode stage (register file plus main control decoder) and the execute stage.
- Captures the decoded control bundle and the operands each cycle.
- Contains load-use hazard detection: on a hazard it inserts a bubble and freezes PC and IF/ID.
- Supports a flush (taken branch or jump) and an external whole-front-end hold.

Parameters:
- DATA_W, 32, width of the operand, immediate and PC datapaths
- REG_ADDR_W, 5, width of register specifiers
- ALU_OP_W, 3, width of the alu_op control field
- CNT_W, 32, width of the performance counters (optional feature only)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction entering EX (branch taken or jump)
- stall_in  in  1  external hold (e.g. memory wait); freezes the stage
- id_valid  in  1  the ID slot holds a real instruction
- id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decoded control bits
- id_alu_op  in  ALU_OP_W  decoded ALU class
- id_pc_plus4, id_rs_data, id_rt_data, id_imm  in  DATA_W  PC+4, operands, sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register specifiers
- id_funct  in  6  R-type funct field
- ex_valid  out  1  the EX slot holds a real instruction
- ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  registered control
- ex_alu_op  out  ALU_OP_W  registered ALU class
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered datapath values
- ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  registered specifiers
- ex_funct  out  6  registered funct
- load_use_stall  out  1  combinational hazard flag
- pc_write, if_id_write  out  1  combinational enables for PC and IF/ID
- bubble_count, stall_count  out  CNT_W  performance counters

Behaviour:
- Reset: while rst_n is low, all ex_* outputs are 0 (ex_valid=0). Reset is asynchronous and takes effect mid-operation, with no pending state.
- Hazard condition:
  - uses_rs = id_valid & ~id_jump
  - uses_rt = id_valid & (id_reg_dst | id_mem_write | id_branch)
  - load_use_stall = ex_valid & ex_mem_read & (ex_rt != 0) & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt))
- Register update each clock edge, in priority order:
  1. flush: load a bubble. All control bits and ex_valid are 0, data fields are 0. pc_write=1, if_id_write=1.
  2. stall_in: hold every ex_* register. pc_write=0, if_id_write=0.
  3. load_use_stall: load a bubble. pc_write=0, if_id_write=0.
  4. otherwise: capture all id_* values, with ex_valid=id_valid. pc_write=1, if_id_write=1.
- Latency: 1 cycle from ID to EX.
- A load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so the held ID instruction advances on the next cycle.
- Simultaneous events:
  - flush with a hazard: flush wins, and PC/IF-ID are not frozen.
  - stall_in with a hazard: hold, and the hazard is re-evaluated after the release.
  - flush with stall_in: flush wins.
- A register 0 destination never raises a hazard.
- id_jump is not forwarded to EX; it only qualifies the hazard check.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Defined: bubble_count increments on each cycle where the bubble is caused by a load-use stall. stall_count increments on each stall_in cycle. Both saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package mips_pkg holds:
  - ALU_OP encodings: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 xor, 110 slt
  - opcode constants
  - width constants
- Sub-module hazard_detect (combinational): computes load_use_stall from the EX load info and the ID specifiers and usage bits.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle with ex_reg_write=1 → all ex_* go to 0 immediately; ex_valid=0.
2. Normal flow: ADD with id_rs=2, id_rt=3, id_rd=4, id_funct=0x20, control reg_dst=1, reg_write=1, alu_op=010 → next edge ex_rd=4, ex_alu_op=010, ex_valid=1, pc_write=1.
3. Load-use: EX holds LW with ex_rt=5; ID holds ADD with id_rs=5 → load_use_stall=1, pc_write=0, if_id_write=0; next edge ex_valid=0 with all control 0; the following edge captures the ADD.
4. No false hazard: EX holds LW with ex_rt=0 and ID uses id_rs=0 → load_use_stall=0. EX holds LW with ex_rt=7 and ID holds ADDI with id_rt=7 → load_use_stall=0 (rt not a source).
5. Flush with a hazard in the same cycle → bubble loaded, pc_write=1. Flush with stall_in → bubble loaded.
6. stall_in high for 3 cycles with a BEQ in EX → ex_* unchanged for 3 edges. With ID_EX_PERF_EN, stall_count=3 and bubble_count increments once per load-use case.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU class encodings, opcodes and datapath widths.
package mips_pkg;

   // Datapath widths used across the pipeline
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned ALU_OP_W_DEF   = 3;
   localparam int unsigned FUNCT_W        = 6;
   localparam int unsigned OPCODE_W       = 6;

   // ALU class produced by the main decoder
   typedef enum logic [2:0] {
      AluAdd   = 3'b000,
      AluSub   = 3'b001,
      AluFunct = 3'b010,
      AluAnd   = 3'b011,
      AluOr    = 3'b100,
      AluXor   = 3'b101,
      AluSlt   = 3'b110
   } alu_op_e;

   // Primary opcodes
   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
   localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0a;
   localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0c;
   localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0d;
   localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0e;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2b;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// register that the load currently in EX has not yet produced.
module hazard_detect #(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  id_valid,
   input  logic                  id_jump,
   input  logic                  id_reg_dst,
   input  logic                  id_mem_write,
   input  logic                  id_branch,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   output logic                  load_use_stall
);

   logic uses_rs;
   logic uses_rt;
   logic ex_load;

   // rt is a source only for R-type, stores and branches; $0 never stalls
   always_comb begin
      uses_rs        = id_valid & ~id_jump;
      uses_rt        = id_valid & (id_reg_dst | id_mem_write | id_branch);
      ex_load        = ex_valid & ex_mem_read & (ex_rt != '0);
      load_use_stall = ex_load & ((uses_rs & (ex_rt == id_rs)) |
                                  (uses_rt & (ex_rt == id_rt)));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional performance counters are enabled by defining ID_EX_PERF_EN.
import mips_pkg::*;

module id_ex_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALU_OP_W   = 3,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  stall_in,
   input  logic                  id_valid,
   input  logic                  id_reg_dst,
   input  logic                  id_jump,
   input  logic                  id_branch,
   input  logic                  id_mem_read,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_write,
   input  logic                  id_alu_src,
   input  logic                  id_reg_write,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic [DATA_W-1:0]     id_pc_plus4,
   input  logic [DATA_W-1:0]     id_rs_data,
   input  logic [DATA_W-1:0]     id_rt_data,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [FUNCT_W-1:0]    id_funct,
   output logic                  ex_valid,
   output logic                  ex_reg_dst,
   output logic                  ex_branch,
   output logic                  ex_mem_read,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_write,
   output logic                  ex_alu_src,
   output logic                  ex_reg_write,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic [DATA_W-1:0]     ex_pc_plus4,
   output logic [DATA_W-1:0]     ex_rs_data,
   output logic [DATA_W-1:0]     ex_rt_data,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [FUNCT_W-1:0]    ex_funct,
   output logic                  load_use_stall,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic [CNT_W-1:0]      bubble_count,
   output logic [CNT_W-1:0]      stall_count
);

   typedef struct packed {
      logic                  valid;
      logic                  reg_dst;
      logic                  branch;
      logic                  mem_read;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  alu_src;
      logic                  reg_write;
      logic [ALU_OP_W-1:0]   alu_op;
      logic [DATA_W-1:0]     pc_plus4;
      logic [DATA_W-1:0]     rs_data;
      logic [DATA_W-1:0]     rt_data;
      logic [DATA_W-1:0]     imm;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [FUNCT_W-1:0]    funct;
   } ex_regs_t;

   ex_regs_t ex_q;
   ex_regs_t ex_d;
   ex_regs_t id_bundle;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .ex_valid       (ex_q.valid),
      .ex_mem_read    (ex_q.mem_read),
      .ex_rt          (ex_q.rt),
      .id_valid       (id_valid),
      .id_jump        (id_jump),
      .id_reg_dst     (id_reg_dst),
      .id_mem_write   (id_mem_write),
      .id_branch      (id_branch),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .load_use_stall (load_use_stall)
   );

   // Gather the decode outputs; id_jump stays behind, it only qualifies the hazard
   always_comb begin
      id_bundle            = '0;
      id_bundle.valid      = id_valid;
      id_bundle.reg_dst    = id_reg_dst;
      id_bundle.branch     = id_branch;
      id_bundle.mem_read   = id_mem_read;
      id_bundle.mem_to_reg = id_mem_to_reg;
      id_bundle.mem_write  = id_mem_write;
      id_bundle.alu_src    = id_alu_src;
      id_bundle.reg_write  = id_reg_write;
      id_bundle.alu_op     = id_alu_op;
      id_bundle.pc_plus4   = id_pc_plus4;
      id_bundle.rs_data    = id_rs_data;
      id_bundle.rt_data    = id_rt_data;
      id_bundle.imm        = id_imm;
      id_bundle.rs         = id_rs;
      id_bundle.rt         = id_rt;
      id_bundle.rd         = id_rd;
      id_bundle.funct      = id_funct;
   end

   // Next EX contents and front-end enables: flush > hold > load-use bubble > advance
   always_comb begin
      ex_d        = id_bundle;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if (flush) begin
         ex_d = '0;
      end else if (stall_in) begin
         ex_d        = ex_q;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (load_use_stall) begin
         ex_d        = '0;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end
   end

   // Pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign ex_valid      = ex_q.valid;
   assign ex_reg_dst    = ex_q.reg_dst;
   assign ex_branch     = ex_q.branch;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_pc_plus4   = ex_q.pc_plus4;
   assign ex_rs_data    = ex_q.rs_data;
   assign ex_rt_data    = ex_q.rt_data;
   assign ex_imm        = ex_q.imm;
   assign ex_rs         = ex_q.rs;
   assign ex_rt         = ex_q.rt;
   assign ex_rd         = ex_q.rd;
   assign ex_funct      = ex_q.funct;

`ifdef ID_EX_PERF_EN
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] stall_q;
   logic             bubble_evt;

   // Only bubbles that actually load because of a hazard are counted
   assign bubble_evt = load_use_stall & ~flush & ~stall_in;

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_q <= '0;
         stall_q  <= '0;
      end else begin
         if (bubble_evt && (bubble_q != '1)) bubble_q <= bubble_q + 1'b1;
         if (stall_in && (stall_q != '1))    stall_q  <= stall_q + 1'b1;
      end
   end

   assign bubble_count = bubble_q;
   assign stall_count  = stall_q;
`else
   assign bubble_count = '0;
   assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expectations from a
// behavioural pipeline model, a negedge monitor pops and compares.
module tb_id_ex_stage;

   localparam int K_ADD = 0, K_LW = 1, K_SW = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5;

   typedef struct packed {
      logic valid, reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
      logic [2:0]  alu_op;
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  funct;
   } id_t;

   typedef struct packed {
      logic valid, reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
      logic [2:0]  alu_op;
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  funct;
   } ex_t;

   typedef struct packed {
      ex_t         ex;
      logic        lus;
      logic        pcw;
      logic [31:0] bub;
      logic [31:0] stl;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0, stall_in = 1'b0, id_valid = 1'b0;
   logic id_reg_dst = 1'b0, id_jump = 1'b0, id_branch = 1'b0, id_mem_read = 1'b0;
   logic id_mem_to_reg = 1'b0, id_mem_write = 1'b0, id_alu_src = 1'b0, id_reg_write = 1'b0;
   logic [2:0]  id_alu_op = '0;
   logic [31:0] id_pc_plus4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
   logic [5:0]  id_funct = '0;
   logic ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
   logic ex_alu_src, ex_reg_write;
   logic [2:0]  ex_alu_op;
   logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [5:0]  ex_funct;
   logic load_use_stall, pc_write, if_id_write;
   logic [31:0] bubble_count, stall_count;

   int tests = 0;
   int fails = 0;
   exp_t exp_q[$];
   ex_t  model = '0;
   logic [31:0] bub_m = '0, stl_m = '0;
   exp_t mon_e;
   ex_t  mon_act;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk (clk), .rst_n (rst_n), .flush (flush), .stall_in (stall_in),
      .id_valid (id_valid), .id_reg_dst (id_reg_dst), .id_jump (id_jump),
      .id_branch (id_branch), .id_mem_read (id_mem_read), .id_mem_to_reg (id_mem_to_reg),
      .id_mem_write (id_mem_write), .id_alu_src (id_alu_src), .id_reg_write (id_reg_write),
      .id_alu_op (id_alu_op), .id_pc_plus4 (id_pc_plus4), .id_rs_data (id_rs_data),
      .id_rt_data (id_rt_data), .id_imm (id_imm), .id_rs (id_rs), .id_rt (id_rt),
      .id_rd (id_rd), .id_funct (id_funct),
      .ex_valid (ex_valid), .ex_reg_dst (ex_reg_dst), .ex_branch (ex_branch),
      .ex_mem_read (ex_mem_read), .ex_mem_to_reg (ex_mem_to_reg),
      .ex_mem_write (ex_mem_write), .ex_alu_src (ex_alu_src), .ex_reg_write (ex_reg_write),
      .ex_alu_op (ex_alu_op), .ex_pc_plus4 (ex_pc_plus4), .ex_rs_data (ex_rs_data),
      .ex_rt_data (ex_rt_data), .ex_imm (ex_imm), .ex_rs (ex_rs), .ex_rt (ex_rt),
      .ex_rd (ex_rd), .ex_funct (ex_funct), .load_use_stall (load_use_stall),
      .pc_write (pc_write), .if_id_write (if_id_write),
      .bubble_count (bubble_count), .stall_count (stall_count)
   );

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ex_t dut_ex();
      ex_t a;
      a = '{ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
            ex_alu_src, ex_reg_write, ex_alu_op, ex_pc_plus4, ex_rs_data, ex_rt_data,
            ex_imm, ex_rs, ex_rt, ex_rd, ex_funct};
      return a;
   endfunction

   // A decoded instruction of a given class with random data payload
   function automatic id_t instr(input int kind, input int rs, input int rt, input int rd);
      id_t i;
      i = '0;
      i.valid   = 1'b1;
      i.rs      = rs[4:0];
      i.rt      = rt[4:0];
      i.rd      = rd[4:0];
      i.pc4     = $urandom;
      i.rs_data = $urandom;
      i.rt_data = $urandom;
      i.imm     = $urandom;
      i.funct   = 6'($urandom);
      case (kind)
         K_ADD:  begin i.reg_dst = 1; i.reg_write = 1; i.alu_op = 3'b010; i.funct = 6'h20; end
         K_LW:   begin i.mem_read = 1; i.mem_to_reg = 1; i.alu_src = 1; i.reg_write = 1; end
         K_SW:   begin i.mem_write = 1; i.alu_src = 1; end
         K_ADDI: begin i.alu_src = 1; i.reg_write = 1; end
         K_BEQ:  begin i.branch = 1; i.alu_op = 3'b001; end
         default: i.jump = 1;
      endcase
      return i;
   endfunction

   function automatic id_t rand_id();
      id_t i;
      i = instr($urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) i.valid = 1'b0;
      return i;
   endfunction

   // Does the ID instruction read a register the EX load will only deliver later?
   function automatic logic hazard(input ex_t e, input id_t i);
      bit reads_rs, reads_rt;
      if (!(e.valid && e.mem_read) || e.rt == 5'd0) return 1'b0;
      reads_rs = i.valid && !i.jump;
      reads_rt = i.valid && (i.reg_dst || i.mem_write || i.branch);
      return (reads_rs && i.rs == e.rt) || (reads_rt && i.rt == e.rt);
   endfunction

   function automatic ex_t advance(input id_t i);
      ex_t e;
      e = '{i.valid, i.reg_dst, i.branch, i.mem_read, i.mem_to_reg, i.mem_write, i.alu_src,
            i.reg_write, i.alu_op, i.pc4, i.rs_data, i.rt_data, i.imm, i.rs, i.rt, i.rd,
            i.funct};
      return e;
   endfunction

   task automatic issue(input id_t i, input bit fl, input bit st);
      exp_t e;
      logic hz;
      @(posedge clk);
      #2;
      flush = fl; stall_in = st;
      id_valid = i.valid; id_reg_dst = i.reg_dst; id_jump = i.jump; id_branch = i.branch;
      id_mem_read = i.mem_read; id_mem_to_reg = i.mem_to_reg; id_mem_write = i.mem_write;
      id_alu_src = i.alu_src; id_reg_write = i.reg_write; id_alu_op = i.alu_op;
      id_pc_plus4 = i.pc4; id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm;
      id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_funct = i.funct;
      hz    = hazard(model, i);
      e.ex  = model;
      e.lus = hz;
      e.pcw = fl | (~st & ~hz);
      e.bub = bub_m;
      e.stl = stl_m;
      exp_q.push_back(e);
`ifdef ID_EX_PERF_EN
      if (!fl && !st && hz) bub_m++;
      if (st) stl_m++;
`endif
      if (fl)       model = '0;
      else if (st)  model = model;
      else if (hz)  model = '0;
      else          model = advance(i);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && exp_q.size() != 0) begin
         mon_e   = exp_q.pop_front();
         mon_act = dut_ex();
         check("ex_regs", 192'(mon_act), 192'(mon_e.ex));
         check("load_use_stall", 192'(load_use_stall), 192'(mon_e.lus));
         check("pc_write", 192'(pc_write), 192'(mon_e.pcw));
         check("if_id_write", 192'(if_id_write), 192'(mon_e.pcw));
         check("bubble_count", 192'(bubble_count), 192'(mon_e.bub));
         check("stall_count", 192'(stall_count), 192'(mon_e.stl));
      end
   end

   initial begin
      id_t nop;
      id_t a;
      nop = '0;
      #3;
      check("reset_ex_regs", 192'(dut_ex()), 192'(0));
      check("reset_counters", {bubble_count, stall_count}, 192'(0));
      #7 rst_n = 1'b1;

      // Normal flow, load-use with held ADD re-issued next cycle
      issue(instr(K_ADD, 2, 3, 4), 0, 0);
      issue(instr(K_LW, 1, 5, 0), 0, 0);
      a = instr(K_ADD, 5, 6, 7);
      issue(a, 0, 0);
      issue(a, 0, 0);
      issue(nop, 0, 0);
      // No false hazards: $0 destination, and rt not a source for ADDI
      issue(instr(K_LW, 1, 0, 0), 0, 0);
      issue(instr(K_ADD, 0, 0, 3), 0, 0);
      issue(instr(K_LW, 1, 7, 0), 0, 0);
      issue(instr(K_ADDI, 1, 7, 0), 0, 0);
      // Flush with hazard, flush with stall
      issue(instr(K_LW, 1, 5, 0), 0, 0);
      issue(instr(K_ADD, 5, 1, 2), 1, 0);
      issue(instr(K_LW, 1, 5, 0), 0, 0);
      issue(instr(K_ADD, 5, 1, 2), 1, 1);
      // Hold a BEQ for three cycles, then a hazard under hold
      issue(instr(K_BEQ, 3, 4, 0), 0, 0);
      for (int k = 0; k < 3; k++) issue(rand_id(), 0, 1);
      issue(instr(K_LW, 1, 6, 0), 0, 0);
      issue(instr(K_SW, 2, 6, 0), 0, 1);
      issue(instr(K_SW, 2, 6, 0), 0, 0);
      issue(instr(K_SW, 2, 6, 0), 0, 0);

      for (int n = 0; n < 400; n++)
         issue(rand_id(), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);

      // Asynchronous reset mid-cycle with a register-writing instruction in EX
      issue(nop, 1, 0);
      issue(instr(K_ADD, 2, 3, 4), 0, 0);
      @(posedge clk);
      #3;
      check("drain", 192'(exp_q.size()), 192'(0));
      check("pre_reset_reg_write", 192'(ex_reg_write), 192'(model.reg_write));
      rst_n = 1'b0;
      #1;
      check("async_reset_ex_regs", 192'(dut_ex()), 192'(0));
      check("async_reset_counters", {bubble_count, stall_count}, 192'(0));
      #10;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
